cf_vector_serializer: RTL and testbench

- Transmit side of the coverage-vector stream. Takes one completed FP operation as a parallel transaction: op code, rounding mode, flags, four format codes, three operands and a result.
- Emits it as a variable-length sequence of 32-bit words with valid/ready handshake and an end-of-record marker.
- Sits between the DUT-side trace tap and the coverage collector / trace writer, which reassembles records using the shared package encodings.

---
 rtl/cf_vector_serializer_pkg.sv | 88 ++++++++
 rtl/cf_vector_serializer_if.sv | 33 +++
 rtl/cf_vector_serializer.sv | 160 ++++++++++++++++
 tb/tb_cf_vector_serializer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cf_vector_serializer_pkg.sv
// rtl/cf_vector_serializer_pkg.sv - shared encodings, state type and field helpers for the vector serializer
// Optional checksum word: COVERFLOAT_CHECKSUM_EN
package cf_vector_serializer_pkg;

  localparam int WORD_W = 32;
  localparam int OPND_W = 128;

  localparam logic [7:0] FMT_HALF   = 8'h00;
  localparam logic [7:0] FMT_SINGLE = 8'h01;
  localparam logic [7:0] FMT_DOUBLE = 8'h02;
  localparam logic [7:0] FMT_QUAD   = 8'h03;
  localparam logic [7:0] FMT_BF16   = 8'h04;
  localparam logic [7:0] FMT_INT    = 8'h81;
  localparam logic [7:0] FMT_LONG   = 8'h82;
  localparam logic [7:0] FMT_UINT   = 8'hC1;
  localparam logic [7:0] FMT_ULONG  = 8'hC2;
  localparam logic [7:0] FMT_INVAL  = 8'hFF;

  localparam int HDR_FMT_A_LSB   = 24;
  localparam int HDR_FMT_B_LSB   = 16;
  localparam int HDR_FMT_C_LSB   = 8;
  localparam int HDR_FMT_RES_LSB = 0;
  localparam int HDR_RM_LSB      = 8;
  localparam int HDR_FLAGS_LSB   = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_OPA,
    S_OPB,
    S_OPC,
    S_RES
`ifdef COVERFLOAT_CHECKSUM_EN
    , S_CSUM
`endif
  } ser_state_e;

  typedef struct packed {
    logic       known;
    logic [2:0] nwords;
  } fmt_info_t;

  function automatic fmt_info_t fmt_num_words(input logic [7:0] fmt);
    fmt_info_t info;
    info.known  = 1'b1;
    info.nwords = 3'd0;
    case (fmt)
      FMT_HALF, FMT_BF16, FMT_SINGLE, FMT_INT, FMT_UINT: info.nwords = 3'd1;
      FMT_DOUBLE, FMT_LONG, FMT_ULONG:                   info.nwords = 3'd2;
      FMT_QUAD:                                          info.nwords = 3'd4;
      FMT_INVAL:                                         info.nwords = 3'd0;
      default:                                           info.known  = 1'b0;
    endcase
    return info;
  endfunction

  // First operand field after cur that has words; present[0]=A .. present[3]=RES.
  function automatic ser_state_e next_field(input ser_state_e cur, input logic [3:0] present);
    ser_state_e nxt;
    int first;
    case (cur)
      S_HDR2:  first = 0;
      S_OPA:   first = 1;
      S_OPB:   first = 2;
      S_OPC:   first = 3;
      default: first = 4;
    endcase
`ifdef COVERFLOAT_CHECKSUM_EN
    nxt = S_CSUM;
`else
    nxt = S_IDLE;
`endif
    for (int i = 3; i >= 0; i--) begin
      if (i >= first && present[i]) begin
        case (i)
          0:       nxt = S_OPA;
          1:       nxt = S_OPB;
          2:       nxt = S_OPC;
          default: nxt = S_RES;
        endcase
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cf_vector_serializer_if.sv
// rtl/cf_vector_serializer_if.sv - transaction input, word stream output and format error pulse
interface cf_vector_serializer_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_op;
  logic [7:0]   in_rm;
  logic [7:0]   in_flags;
  logic [7:0]   in_fmt_a;
  logic [7:0]   in_fmt_b;
  logic [7:0]   in_fmt_c;
  logic [7:0]   in_fmt_res;
  logic [127:0] in_a;
  logic [127:0] in_b;
  logic [127:0] in_c;
  logic [127:0] in_res;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         fmt_err;

  modport master (
    output in_valid, in_op, in_rm, in_flags, in_fmt_a, in_fmt_b, in_fmt_c, in_fmt_res,
           in_a, in_b, in_c, in_res, out_ready,
    input  in_ready, out_valid, out_data, out_last, fmt_err
  );

  modport slave (
    input  in_valid, in_op, in_rm, in_flags, in_fmt_a, in_fmt_b, in_fmt_c, in_fmt_res,
           in_a, in_b, in_c, in_res, out_ready,
    output in_ready, out_valid, out_data, out_last, fmt_err
  );
endinterface

// File: rtl/cf_vector_serializer.sv
// rtl/cf_vector_serializer.sv - serializes one FP operation record into a 32-bit word stream
// Optional trailing XOR checksum word: COVERFLOAT_CHECKSUM_EN
module cf_vector_serializer
  import cf_vector_serializer_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  cf_vector_serializer_if.slave bus
);

  ser_state_e        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       op_q, op_d;
  logic [31:0]       fmts_q, fmts_d;
  logic [15:0]       ctl_q, ctl_d;
  logic [OPND_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d;
  logic              fmt_err_q, fmt_err_d;
`ifdef COVERFLOAT_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;
`endif

  fmt_info_t         info_a, info_b, info_c, info_r;
  logic [3:0]        present;
  logic [2:0]        cur_n;
  logic [OPND_W-1:0] cur_opnd;
  logic              in_fmt_bad, accept, xfer, out_valid, out_last;
  logic [WORD_W-1:0] out_data;
  ser_state_e        adv_state;
  logic [1:0]        adv_idx;

  always_comb begin
    info_a  = fmt_num_words(fmts_q[HDR_FMT_A_LSB +: 8]);
    info_b  = fmt_num_words(fmts_q[HDR_FMT_B_LSB +: 8]);
    info_c  = fmt_num_words(fmts_q[HDR_FMT_C_LSB +: 8]);
    info_r  = fmt_num_words(fmts_q[HDR_FMT_RES_LSB +: 8]);
    present = {info_r.nwords != 3'd0, info_c.nwords != 3'd0,
               info_b.nwords != 3'd0, info_a.nwords != 3'd0};
    in_fmt_bad = !fmt_num_words(bus.in_fmt_a).known || !fmt_num_words(bus.in_fmt_b).known ||
                 !fmt_num_words(bus.in_fmt_c).known || !fmt_num_words(bus.in_fmt_res).known;

    accept    = bus.in_valid && (state_q == S_IDLE);
    out_valid = (state_q != S_IDLE);
    xfer      = out_valid && bus.out_ready;

    cur_n    = 3'd0;
    cur_opnd = '0;
    case (state_q)
      S_OPA:   begin cur_n = info_a.nwords; cur_opnd = a_q;   end
      S_OPB:   begin cur_n = info_b.nwords; cur_opnd = b_q;   end
      S_OPC:   begin cur_n = info_c.nwords; cur_opnd = c_q;   end
      S_RES:   begin cur_n = info_r.nwords; cur_opnd = res_q; end
      default: ;
    endcase

    // Word mux is driven only from registered state, so it holds under backpressure.
    out_data = '0;
    case (state_q)
      S_HDR0:                     out_data = op_q;
      S_HDR1:                     out_data = fmts_q;
      S_HDR2:                     out_data = {16'h0, ctl_q};
      S_OPA, S_OPB, S_OPC, S_RES: out_data = cur_opnd[{idx_q, 5'b0} +: WORD_W];
`ifdef COVERFLOAT_CHECKSUM_EN
      S_CSUM:                     out_data = csum_q;
`endif
      default:                    out_data = '0;
    endcase

    adv_state = S_IDLE;
    adv_idx   = 2'd0;
    case (state_q)
      S_HDR0: adv_state = S_HDR1;
      S_HDR1: adv_state = S_HDR2;
      S_HDR2: adv_state = next_field(S_HDR2, present);
      S_OPA, S_OPB, S_OPC, S_RES: begin
        if ({1'b0, idx_q} != cur_n - 3'd1) begin
          adv_state = state_q;
          adv_idx   = idx_q + 2'd1;
        end else begin
          adv_state = next_field(state_q, present);
        end
      end
      default: adv_state = S_IDLE;
    endcase
    out_last = out_valid && (adv_state == S_IDLE);

    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    fmts_d    = fmts_q;
    ctl_d     = ctl_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    res_d     = res_q;
    fmt_err_d = 1'b0;
`ifdef COVERFLOAT_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    if (accept) begin
      state_d   = S_HDR0;
      idx_d     = 2'd0;
      op_d      = bus.in_op;
      fmts_d    = {bus.in_fmt_a, bus.in_fmt_b, bus.in_fmt_c, bus.in_fmt_res};
      ctl_d     = {bus.in_rm, bus.in_flags};
      a_d       = bus.in_a;
      b_d       = bus.in_b;
      c_d       = bus.in_c;
      res_d     = bus.in_res;
      fmt_err_d = in_fmt_bad;
`ifdef COVERFLOAT_CHECKSUM_EN
      csum_d    = '0;
`endif
    end else if (xfer) begin
      state_d = adv_state;
      idx_d   = adv_idx;
`ifdef COVERFLOAT_CHECKSUM_EN
      csum_d  = csum_q ^ out_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      op_q      <= '0;
      fmts_q    <= '0;
      ctl_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      res_q     <= '0;
      fmt_err_q <= 1'b0;
`ifdef COVERFLOAT_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      fmts_q    <= fmts_d;
      ctl_q     <= ctl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      res_q     <= res_d;
      fmt_err_q <= fmt_err_d;
`ifdef COVERFLOAT_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_cf_vector_serializer.sv
// tb/tb_cf_vector_serializer.sv - scoreboard bench for cf_vector_serializer
module tb_cf_vector_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cf_vector_serializer_if bus();
  cf_vector_serializer dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int err_pulses = 0;
  logic [32:0] exp_q[$];

  always @(negedge clk) if (bus.fmt_err === 1'b1) err_pulses++;

  function automatic int tb_nw(input logic [7:0] f);
    case (f)
      8'h00, 8'h01, 8'h04, 8'h81, 8'hC1: return 1;
      8'h02, 8'h82, 8'hC2:               return 2;
      8'h03:                             return 4;
      default:                           return 0;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_record(input logic [31:0] op, input logic [7:0] rm, input logic [7:0] flags,
                             input logic [7:0] fa, input logic [7:0] fb, input logic [7:0] fc,
                             input logic [7:0] fr, input logic [127:0] a, input logic [127:0] b,
                             input logic [127:0] c, input logic [127:0] r);
    logic [31:0]  w[$];
    logic [127:0] ops[4];
    logic [7:0]   fm[4];
    logic [31:0]  x;
    ops = '{a, b, c, r};
    fm  = '{fa, fb, fc, fr};
    w.push_back(op);
    w.push_back({fa, fb, fc, fr});
    w.push_back({16'h0, rm, flags});
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < tb_nw(fm[i]); j++)
        w.push_back(ops[i][32*j +: 32]);
`ifdef COVERFLOAT_CHECKSUM_EN
    x = 32'h0;
    foreach (w[k]) x = x ^ w[k];
    w.push_back(x);
`endif
    foreach (w[k]) exp_q.push_back({k == w.size() - 1, w[k]});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] op, input logic [7:0] rm, input logic [7:0] flags,
                      input logic [7:0] fa, input logic [7:0] fb, input logic [7:0] fc,
                      input logic [7:0] fr, input logic [127:0] a, input logic [127:0] b,
                      input logic [127:0] c, input logic [127:0] r);
    int t = 0;
    bus.in_op = op; bus.in_rm = rm; bus.in_flags = flags;
    bus.in_fmt_a = fa; bus.in_fmt_b = fb; bus.in_fmt_c = fc; bus.in_fmt_res = fr;
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_res = r;
    bus.in_valid = 1'b1;
    push_record(op, rm, flags, fa, fb, fc, fr, a, b, c, r);
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t == 20) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op = $urandom(); bus.in_fmt_a = 8'h07; bus.in_a = rnd128(); bus.in_res = rnd128();
    n_tests++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_word_latency: out_valid=%b required 1", bus.out_valid);
    end
  endtask

  // mode 0: always ready, 1: ready 1,0,0,1 then 1, 2: random ready
  task automatic stream(input int mode, input int max_xfers, output int xfers, output int holds);
    int cyc = 0;
    logic pv = 1'b0;
    logic [31:0] pd;
    logic pl;
    logic rdy;
    logic [32:0] e;
    xfers = 0;
    holds = 0;
    while (exp_q.size() > 0 && xfers < max_xfers && cyc < 2000) begin
      case (mode)
        1:       rdy = !(cyc == 1 || cyc == 2);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      bus.out_ready = rdy;
      if (pv) begin
        n_tests++;
        holds++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_last !== pl) begin
          n_fail++;
          $display("FAIL hold: valid=%b data=%h last=%b required 1 %h %b",
                   bus.out_valid, bus.out_data, bus.out_last, pd, pl);
        end
      end
      if (bus.out_valid === 1'b1 && rdy) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.out_data !== e[31:0] || bus.out_last !== e[32]) begin
          n_fail++;
          $display("FAIL word%0d: data=%h last=%b required %h %b",
                   xfers, bus.out_data, bus.out_last, e[31:0], e[32]);
        end
        xfers++;
        pv = 1'b0;
      end else begin
        pv = (bus.out_valid === 1'b1);
        pd = bus.out_data;
        pl = bus.out_last;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b1;
    if (exp_q.size() > 0 && xfers < max_xfers) begin
      n_tests++;
      n_fail++;
      $display("FAIL stream_timeout: %0d words outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: in_ready=%b out_valid=%b required 1 0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic check_err(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: fmt_err pulses=%0d required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 ||
        bus.out_last !== 1'b0 || bus.fmt_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b data=%h last=%b err=%b required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.fmt_err);
    end
  endtask

  task automatic test_single_add();
    int x, h, e0;
    e0 = err_pulses;
    send(32'h10, 8'h0, 8'h0, 8'h01, 8'h01, 8'hFF, 8'h01,
         128'h3F800000, 128'h40000000, 128'h0, 128'h40400000);
    stream(0, 1000, x, h);
    n_tests++;
`ifdef COVERFLOAT_CHECKSUM_EN
    if (x != 7) begin n_fail++; $display("FAIL add_count: %0d required 7", x); end
`else
    if (x != 6) begin n_fail++; $display("FAIL add_count: %0d required 6", x); end
`endif
    check_idle("add_idle");
    check_err("add_err", err_pulses - e0, 0);
  endtask

  task automatic test_quad_fmadd();
    int x, h;
    send(32'h51, 8'h2, 8'h1, 8'h03, 8'h03, 8'h03, 8'h03, rnd128(), rnd128(), rnd128(), rnd128());
    stream(0, 1000, x, h);
    n_tests++;
`ifdef COVERFLOAT_CHECKSUM_EN
    if (x != 20) begin n_fail++; $display("FAIL quad_count: %0d required 20", x); end
`else
    if (x != 19) begin n_fail++; $display("FAIL quad_count: %0d required 19", x); end
`endif
    check_idle("quad_idle");
  endtask

  task automatic test_backpressure();
    int x, h;
    send(32'h10, 8'h0, 8'h0, 8'h01, 8'h01, 8'hFF, 8'h01,
         128'h3F800000, 128'h40000000, 128'h0, 128'h40400000);
    stream(1, 1000, x, h);
    n_tests++;
    if (h != 2) begin n_fail++; $display("FAIL bp_holds: %0d required 2", h); end
    check_idle("bp_idle");
  endtask

  task automatic test_unknown_fmt();
    int x, h, e0;
    e0 = err_pulses;
    send(32'h22, 8'h1, 8'h10, 8'h02, 8'h07, 8'h01, 8'h02, rnd128(), rnd128(), rnd128(), rnd128());
    stream(2, 1000, x, h);
    check_idle("unk_idle");
    check_err("unk_err", err_pulses - e0, 1);
  endtask

  task automatic test_reset_mid();
    int x, h;
    send(32'h33, 8'h0, 8'h0, 8'h02, 8'h02, 8'h02, 8'h02, rnd128(), rnd128(), rnd128(), rnd128());
    stream(0, 2, x, h);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_last !== 1'b0 ||
        bus.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: vld=%b rdy=%b last=%b data=%h required 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.out_last, bus.out_data);
    end
    send(32'h44, 8'h3, 8'h5, 8'h02, 8'hC2, 8'h82, 8'h02, rnd128(), rnd128(), rnd128(), rnd128());
    stream(0, 1000, x, h);
    check_idle("mid_after_idle");
  endtask

  task automatic test_back_to_back();
    int x, h;
    send(32'h61, 8'h1, 8'h2, 8'h00, 8'h04, 8'h81, 8'hC1, rnd128(), rnd128(), rnd128(), rnd128());
    stream(2, 1000, x, h);
    check_idle("b2b_gap");
    send(32'h62, 8'h4, 8'h8, 8'h02, 8'hFF, 8'h03, 8'hFF, rnd128(), rnd128(), rnd128(), rnd128());
    stream(2, 1000, x, h);
    check_idle("b2b_idle");
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_op = '0; bus.in_rm = '0; bus.in_flags = '0;
    bus.in_fmt_a = '0; bus.in_fmt_b = '0; bus.in_fmt_c = '0; bus.in_fmt_res = '0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_res = '0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_quad_fmadd();
    test_backpressure();
    test_unknown_fmt();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
